// File: rtl/param_seq_alu.sv
// param_seq_alu: WIDTH-bit sequential ALU for the EX stage.
// Single-cycle ops complete on the start edge; MUL (shift-add) and DIV/MOD
// (restoring divide) iterate one bit per cycle under a start/busy/done handshake.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   start               request, sampled only while idle
//   alu_control[4:0]    opcode, sampled with start
//   a, b [WIDTH-1:0]    operands, sampled with start
//   busy                multi-cycle operation in progress
//   done                one-cycle pulse when result/flags update
//   result[WIDTH-1:0]   registered result, held until next completion
//   flag_eq/gt/dz       registered a==b, a>b (unsigned), divide-by-zero
module param_seq_alu #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [4:0]       alu_control,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             flag_eq,
    output logic             flag_gt,
    output logic             flag_dz
);

    localparam int unsigned SHW = $clog2(WIDTH);
    localparam int unsigned CW  = $clog2(WIDTH + 1);

    localparam logic [4:0] OP_ADD = 5'b00000;
    localparam logic [4:0] OP_SUB = 5'b00001;
    localparam logic [4:0] OP_MUL = 5'b00010;
    localparam logic [4:0] OP_DIV = 5'b00011;
    localparam logic [4:0] OP_MOD = 5'b00100;
    localparam logic [4:0] OP_CMP = 5'b00101;
    localparam logic [4:0] OP_AND = 5'b00110;
    localparam logic [4:0] OP_OR  = 5'b00111;
    localparam logic [4:0] OP_NOT = 5'b01000;
    localparam logic [4:0] OP_SLL = 5'b01001;
    localparam logic [4:0] OP_SRL = 5'b01010;
    localparam logic [4:0] OP_SRA = 5'b01011;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2
    } state_e;

    state_e           state_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] result_q;
    logic             flag_eq_q;
    logic             flag_gt_q;
    logic             flag_dz_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             op_mod_q;
    logic [WIDTH-1:0] x_q;    // MUL: shifted multiplicand; DIV: dividend shifting into quotient
    logic [WIDTH-1:0] y_q;    // MUL: multiplier, consumed LSB first
    logic [WIDTH-1:0] acc_q;  // MUL: partial product; DIV: partial remainder

    logic [SHW-1:0]   shamt_c;
    logic [WIDTH-1:0] sc_result_c;
    logic             is_mul_c;
    logic             is_divmod_c;
    logic             is_div_c;
    logic             is_dz_c;

    logic [WIDTH-1:0] mul_acc_c;
    logic [WIDTH:0]   rem_sh_c;
    logic             div_ge_c;
    logic [WIDTH:0]   rem_n_c;
    logic [WIDTH-1:0] quo_n_c;
    logic [WIDTH-1:0] x_d;
    logic [WIDTH-1:0] y_d;
    logic [WIDTH-1:0] acc_d;
    logic [WIDTH-1:0] fin_c;
    logic             rem_msb_unused;

    assign busy    = busy_q;
    assign done    = done_q;
    assign result  = result_q;
    assign flag_eq = flag_eq_q;
    assign flag_gt = flag_gt_q;
    assign flag_dz = flag_dz_q;

    // Request classification at the start edge
    assign shamt_c     = b[SHW-1:0];
    assign is_mul_c    = (alu_control == OP_MUL);
    assign is_divmod_c = (alu_control == OP_DIV) || (alu_control == OP_MOD);
    assign is_div_c    = is_divmod_c && (b != '0);
    assign is_dz_c     = is_divmod_c && (b == '0);

    // Single-cycle result; DIV/MOD by zero falls to the zero default
    always_comb begin
        sc_result_c = '0;
        case (alu_control)
            OP_ADD: sc_result_c = a + b;
            OP_SUB: sc_result_c = a - b;
            OP_CMP: begin
                if (a < b)      sc_result_c = '1;
                else if (a > b) sc_result_c = WIDTH'(1);
                else            sc_result_c = '0;
            end
            OP_AND: sc_result_c = a & b;
            OP_OR:  sc_result_c = a | b;
            OP_NOT: sc_result_c = ~a;
            OP_SLL: sc_result_c = a << shamt_c;
            OP_SRL: sc_result_c = a >> shamt_c;
            OP_SRA: sc_result_c = WIDTH'($signed(a) >>> shamt_c);
            default: sc_result_c = '0;
        endcase
    end

    // One iteration of shift-add multiply or restoring divide
    always_comb begin
        mul_acc_c = acc_q + (y_q[0] ? x_q : '0);
        rem_sh_c  = {acc_q, x_q[WIDTH-1]};
        div_ge_c  = (rem_sh_c >= {1'b0, b_q});
        rem_n_c   = div_ge_c ? (rem_sh_c - {1'b0, b_q}) : rem_sh_c;
        quo_n_c   = {x_q[WIDTH-2:0], div_ge_c};
        x_d       = x_q << 1;
        y_d       = y_q >> 1;
        acc_d     = mul_acc_c;
        fin_c     = mul_acc_c;
        if (state_q == S_DIV) begin
            x_d   = quo_n_c;
            y_d   = y_q;
            acc_d = rem_n_c[WIDTH-1:0];
            fin_c = op_mod_q ? rem_n_c[WIDTH-1:0] : quo_n_c;
        end
    end

    // Remainder after a subtract is always below the divisor, so its top bit is zero
    assign rem_msb_unused = rem_n_c[WIDTH];

    // Sequencer and all architectural registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= '0;
            flag_eq_q <= 1'b0;
            flag_gt_q <= 1'b0;
            flag_dz_q <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            op_mod_q  <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
            acc_q     <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        a_q      <= a;
                        b_q      <= b;
                        op_mod_q <= (alu_control == OP_MOD);
                        if (is_mul_c || is_div_c) begin
                            state_q <= is_mul_c ? S_MUL : S_DIV;
                            busy_q  <= 1'b1;
                            cnt_q   <= CW'(WIDTH);
                            x_q     <= a;
                            y_q     <= b;
                            acc_q   <= '0;
                        end else begin
                            result_q  <= sc_result_c;
                            flag_eq_q <= (a == b);
                            flag_gt_q <= (a > b);
                            flag_dz_q <= is_dz_c;
                            done_q    <= 1'b1;
                        end
                    end
                end
                S_MUL, S_DIV: begin
                    cnt_q <= cnt_q - CW'(1);
                    x_q   <= x_d;
                    y_q   <= y_d;
                    acc_q <= acc_d;
                    // Last iteration: publish result on the edge the counter hits zero
                    if (cnt_q == CW'(1)) begin
                        state_q   <= S_IDLE;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        result_q  <= fin_c;
                        flag_eq_q <= (a_q == b_q);
                        flag_gt_q <= (a_q > b_q);
                        flag_dz_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/param_seq_alu.md
Name: param_seq_alu

Overview:
Parametrised, clocked successor to the tinyRisc combinational ALU. It keeps the same 5-bit opcode map but generalises the datapath to WIDTH bits. MUL, DIV and MOD run as iterative multi-cycle operations under a start/busy/done handshake. Status flags are registered, with no latches. It sits in the EX stage, and the pipeline stalls on busy.

Parameters:
WIDTH, 32, operand/result width in bits (>=4, power of two)
SHW, $clog2(WIDTH), number of low bits of b used as shift amount (derived; do not override)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only while not busy
alu_control  input  5  opcode, sampled with start
a  input  WIDTH  operand A, sampled with start
b  input  WIDTH  operand B, sampled with start
busy  output  1  multi-cycle operation in progress
done  output  1  one-cycle pulse: result/flags updated this cycle
result  output  WIDTH  registered result, held until the next completion
flag_eq  output  1  registered: a==b of the last completed op
flag_gt  output  1  registered: a>b (unsigned) of the last completed op
flag_dz  output  1  registered: last completed op was DIV/MOD with b==0

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - busy, done, result, all flags = 0.
  - Iteration counter and internal registers cleared.
  - Reset mid-operation aborts it; no done is produced.
- Opcodes (all unsigned unless noted):
  - 00000 ADD: a+b mod 2^WIDTH
  - 00001 SUB: a-b mod 2^WIDTH
  - 00010 MUL: low WIDTH bits of a*b
  - 00011 DIV: a/b
  - 00100 MOD: a%b
  - 00101 CMP: 0 if equal, all-ones (-1) if a<b, 1 if a>b
  - 00110 AND
  - 00111 OR
  - 01000 NOT: ~a
  - 01001 SLL: a << b[SHW-1:0]
  - 01010 SRL: logical a >> b[SHW-1:0]
  - 01011 SRA: arithmetic shift right, sign = a[WIDTH-1]
  - all other codes: result 0
- FSM states: IDLE, MUL, DIV.
- IDLE, start=1 at edge T0 with a single-cycle op (everything except MUL, DIV/MOD with b!=0):
  - result and flags registered at T0.
  - done=1 for the cycle after T0; busy stays 0.
  - Back-to-back starts on consecutive cycles are legal and give one done per start.
- DIV/MOD with b==0: treated as single-cycle. result=0, flag_dz=1, done next cycle.
- IDLE, start=1 with MUL (or DIV/MOD with b!=0):
  - Operands latched at T0; go to MUL/DIV; busy=1 from T0 onward.
  - counter loads WIDTH.
- MUL state: shift-add, one multiplier bit per cycle, LSB first.
- DIV state: restoring divide, one quotient bit per cycle, MSB first. Partial remainder is WIDTH+1 bits.
- Counter decrements each cycle. At the edge where it reaches 0 (edge T0+WIDTH):
  - result registered (quotient for DIV, remainder for MOD), flags registered.
  - busy falls; done=1 for the following cycle; state returns to IDLE.
- Latency: MUL/DIV/MOD = WIDTH cycles from start edge to done; all other ops = 1 cycle.
- start while busy=1 is ignored; operands and opcode are not re-sampled.
- start in the same cycle that done is high is accepted; that cycle is idle.
- Flags on every completion:
  - flag_eq and flag_gt computed from the latched operands.
  - flag_dz=1 only for DIV/MOD with b==0, else 0.
- result and flags hold their values between completions; done is never high for two consecutive cycles from a single start.
- No combinational path from inputs to outputs.

Test Plan:
- Reset then ADD a=0xFFFFFFFF, b=1 (WIDTH=32) -> next cycle done=1, result=0, flag_gt=1, flag_eq=0, busy never 1.
- MUL a=0x00012345, b=0x00010000 -> busy high 32 cycles; done on cycle 32; result=0x23450000 (truncated); start pulses during busy ignored.
- DIV a=100, b=7, then immediately MOD with same operands -> result=14, then result=2, each after 32 cycles; flag_gt=1.
- DIV a=5, b=0 -> done after 1 cycle; result=0; flag_dz=1. Following ADD clears flag_dz to 0.
- SRA a=0x80000000, b=0x21 (shift 1) -> 0xC0000000. SRL same -> 0x40000000. CMP a=3, b=9 -> 0xFFFFFFFF. Opcode 11111 -> 0.
- Assert rst_n=0 at cycle 10 of a MUL -> busy/done/result/flags 0 immediately. After release, a new ADD 2+3 -> 5 with a single done pulse.
